bcm_scan_controller: RTL and testbench

Sequencer for the LED matrix frame memory and panel drive pins. Walks every scan row and every BCM bit plane, runs the column shift burst against the frame memory (`shift_en`, `scan_val`, `current_bcm_bit`), then blanks, latches and displays each bit plane for a binary-weighted time. It sits between the frame memory's shift interface and the HUB75 panel control pins (CLK enable, LAT, OE_n, row address). A processor-side enable starts and stops it.

---
 rtl/bcm_scan_controller.sv | 162 ++++++++++++++++
 tb/tb_bcm_scan_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcm_scan_controller.sv
// BCM scan sequencer: shifts each row/bit plane from frame memory,
// then blanks, latches and displays it for a binary-weighted time.
module bcm_scan_controller #(
  parameter int MATRIX_WIDTH    = 64,
  parameter int DATA_WIDTH      = 8,
  parameter int SCAN_VAL_LENGTH = 5,
  parameter int SCAN_ROWS       = 16,
  parameter int BASE_TIME       = 8,
  parameter int BLANK_CYCLES    = 2,
  parameter int COL_CNT_WIDTH   = 7,
  parameter int DISP_CNT_WIDTH  = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       shift_reg_empty,
  output logic [SCAN_VAL_LENGTH-1:0] scan_val,
  output logic [DATA_WIDTH-1:0]      current_bcm_bit,
  output logic                       shift_en,
  output logic                       panel_clk_en,
  output logic                       panel_lat,
  output logic                       panel_oe_n,
  output logic [SCAN_VAL_LENGTH-1:0] row_addr,
  output logic                       frame_done,
  output logic                       busy,
  output logic                       sync_error
);

  localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [COL_CNT_WIDTH-1:0] COL_ONE = COL_CNT_WIDTH'(1);
  localparam logic [COL_CNT_WIDTH-1:0] COL_END = COL_CNT_WIDTH'(MATRIX_WIDTH);
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);
  localparam logic [DISP_CNT_WIDTH-1:0] DSP_ONE  = DISP_CNT_WIDTH'(1);
  localparam logic [DISP_CNT_WIDTH-1:0] DSP_BASE = DISP_CNT_WIDTH'(BASE_TIME);
  localparam logic [DATA_WIDTH-1:0] BIT_ONE  = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] BIT_LAST = DATA_WIDTH'(DATA_WIDTH - 1);
  localparam logic [SCAN_VAL_LENGTH-1:0] ROW_ONE  = SCAN_VAL_LENGTH'(1);
  localparam logic [SCAN_VAL_LENGTH-1:0] ROW_LAST = SCAN_VAL_LENGTH'(SCAN_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    DRAIN,
    BLANK,
    LATCH,
    DISPLAY
  } state_t;

  state_t state;
  state_t state_nx;

  logic [COL_CNT_WIDTH-1:0]  col_cnt;
  logic [COL_CNT_WIDTH-1:0]  col_inc;
  logic [BLK_W-1:0]          blank_cnt;
  logic [DISP_CNT_WIDTH-1:0] disp_cnt;
  logic [DISP_CNT_WIDTH-1:0] disp_len;
  logic                      col_last;
  logic                      blank_last;
  logic                      disp_last;
  logic                      plane_last;
  logic                      row_last;

  // col_inc is the 1-based index of the current shift cycle
  assign col_inc    = col_cnt + COL_ONE;
  assign col_last   = (col_inc == COL_END);
  assign blank_last = (blank_cnt == BLK_LAST);
  assign disp_len   = DSP_BASE << current_bcm_bit;
  assign disp_last  = ((disp_cnt + DSP_ONE) == disp_len);
  assign plane_last = (current_bcm_bit == BIT_LAST);
  assign row_last   = (scan_val == ROW_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    shift_en   = 1'b0;
    panel_lat  = 1'b0;
    panel_oe_n = 1'b1;
    busy       = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (enable) state_nx = SHIFT;
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (col_last) state_nx = DRAIN;
      end
      DRAIN: state_nx = BLANK;
      BLANK: begin
        if (blank_last) state_nx = LATCH;
      end
      LATCH: begin
        panel_lat = 1'b1;
        state_nx  = DISPLAY;
      end
      DISPLAY: begin
        panel_oe_n = 1'b0;
        if (disp_last) state_nx = enable ? SHIFT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt   <= '0;
      blank_cnt <= '0;
      disp_cnt  <= '0;
    end else begin
      col_cnt   <= (state == SHIFT) ? col_inc : '0;
      blank_cnt <= (state == BLANK) ? blank_cnt + BLK_ONE : '0;
      disp_cnt  <= (state == DISPLAY) ? disp_cnt + DSP_ONE : '0;
    end
  end

  // Position only moves on the display exit edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_val        <= '0;
      current_bcm_bit <= '0;
      frame_done      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == DISPLAY && disp_last) begin
        if (plane_last) begin
          current_bcm_bit <= '0;
          if (row_last) begin
            scan_val   <= '0;
            frame_done <= 1'b1;
          end else begin
            scan_val <= scan_val + ROW_ONE;
          end
        end else begin
          current_bcm_bit <= current_bcm_bit + BIT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      panel_clk_en <= 1'b0;
      row_addr     <= '0;
      sync_error   <= 1'b0;
    end else begin
      panel_clk_en <= shift_en;
      if (state == BLANK && blank_last) row_addr <= scan_val;
      if (state == SHIFT && shift_reg_empty && !col_last) sync_error <= 1'b1;
      if (state == DRAIN && !shift_reg_empty) sync_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcm_scan_controller.sv
// Self-checking bench for bcm_scan_controller on a small panel:
// cycle-table checks plus a latch/display scoreboard.
module tb_bcm_scan_controller;

  localparam int MW  = 4;
  localparam int DW  = 2;
  localparam int SVL = 5;
  localparam int SR  = 2;
  localparam int BT  = 2;
  localparam int BC  = 1;
  localparam int CW  = 7;
  localparam int DCW = 20;
  localparam int FRAME = 40;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic           shift_reg_empty;
  logic [SVL-1:0] scan_val;
  logic [DW-1:0]  current_bcm_bit;
  logic           shift_en;
  logic           panel_clk_en;
  logic           panel_lat;
  logic           panel_oe_n;
  logic [SVL-1:0] row_addr;
  logic           frame_done;
  logic           busy;
  logic           sync_error;

  bcm_scan_controller #(
    .MATRIX_WIDTH(MW),
    .DATA_WIDTH(DW),
    .SCAN_VAL_LENGTH(SVL),
    .SCAN_ROWS(SR),
    .BASE_TIME(BT),
    .BLANK_CYCLES(BC),
    .COL_CNT_WIDTH(CW),
    .DISP_CNT_WIDTH(DCW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .shift_reg_empty(shift_reg_empty),
    .scan_val(scan_val),
    .current_bcm_bit(current_bcm_bit),
    .shift_en(shift_en),
    .panel_clk_en(panel_clk_en),
    .panel_lat(panel_lat),
    .panel_oe_n(panel_oe_n),
    .row_addr(row_addr),
    .frame_done(frame_done),
    .busy(busy),
    .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  // Frame memory shift counter: flag high on last shift and the cycle after
  int   mem_cnt;
  logic prev_se;
  logic inj = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cnt <= 0;
      prev_se <= 1'b0;
    end else begin
      prev_se <= shift_en;
      mem_cnt <= shift_en ? mem_cnt + 1 : 0;
    end
  end
  assign shift_reg_empty = inj | (shift_en && mem_cnt == MW - 1)
                         | (prev_se && !shift_en);

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  longint cyc_g = 0;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  typedef struct {
    logic [SVL-1:0] row;
    int             run;
  } lat_t;
  lat_t sbq[$];

  logic   mon_on = 1'b0;
  int     sh_run, ce_run, oe_run, since_ce, exp_run;
  bit     have_run;
  longint last_fd = -1;

  always @(negedge clk) begin
    lat_t r;
    if (!mon_on) begin
      sh_run = 0; ce_run = 0; oe_run = 0;
      since_ce = 99; have_run = 0;
    end else begin
      if (shift_en) sh_run++;
      else if (sh_run != 0) begin
        chk("burst_len", sh_run, MW);
        sh_run = 0;
      end
      if (panel_clk_en) begin
        ce_run++;
        since_ce = 0;
      end else begin
        if (ce_run != 0) begin
          chk("clk_pulses", ce_run, MW);
          ce_run = 0;
        end
        since_ce++;
      end
      if (panel_lat) begin
        chk("lat_oe_overlap", panel_oe_n, 1);
        chk("lat_gap", since_ce, BC + 1);
        if (sbq.size() == 0) begin
          chk("unexpected_latch", 1, 0);
        end else begin
          r = sbq.pop_front();
          chk("latch_row", row_addr, r.row);
          exp_run = r.run;
          have_run = 1;
        end
      end
      if (!panel_oe_n) oe_run++;
      else if (oe_run != 0) begin
        chk("oe_run", oe_run, have_run ? exp_run : -1);
        oe_run = 0;
        have_run = 0;
      end
      if (frame_done) begin
        if (last_fd >= 0) chk("frame_period", cyc_g - last_fd, FRAME);
        last_fd = cyc_g;
      end
    end
  end

  typedef struct {
    int             cyc;
    logic           se, ce, lat, oe_n, bsy, fd;
    logic [SVL-1:0] row, scan;
    logic [DW-1:0]  bcm;
  } vec_t;

  function automatic longint pack(input logic se, ce, lat, oe_n, bsy, fd,
                                  input logic [SVL-1:0] row, scan,
                                  input logic [DW-1:0] bcm);
    return longint'({se, ce, lat, oe_n, bsy, fd, row, scan, bcm});
  endfunction

  function automatic longint outs();
    return pack(shift_en, panel_clk_en, panel_lat, panel_oe_n, busy,
                frame_done, row_addr, scan_val, current_bcm_bit);
  endfunction

  vec_t tbl[$];
  int   n;

  initial begin
    // cyc se ce lat oe busy fd row scan bit
    tbl = '{
      '{0,  1, 0, 0, 1, 1, 0, 0, 0, 0},
      '{4,  0, 1, 0, 1, 1, 0, 0, 0, 0},
      '{5,  0, 0, 0, 1, 1, 0, 0, 0, 0},
      '{6,  0, 0, 1, 1, 1, 0, 0, 0, 0},
      '{7,  0, 0, 0, 0, 1, 0, 0, 0, 0},
      '{8,  0, 0, 0, 0, 1, 0, 0, 0, 0},
      '{9,  1, 0, 0, 1, 1, 0, 0, 0, 1},
      '{15, 0, 0, 1, 1, 1, 0, 0, 0, 1},
      '{19, 0, 0, 0, 0, 1, 0, 0, 0, 1},
      '{20, 1, 0, 0, 1, 1, 0, 0, 1, 0},
      '{26, 0, 0, 1, 1, 1, 0, 1, 1, 0},
      '{35, 0, 0, 1, 1, 1, 0, 1, 1, 1},
      '{39, 0, 0, 0, 0, 1, 0, 1, 1, 1},
      '{40, 1, 0, 0, 1, 1, 1, 1, 0, 0},
      '{41, 1, 1, 0, 1, 1, 0, 1, 0, 0}
    };

    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), pack(0, 0, 0, 1, 0, 0, 0, 0, 0));
    chk("reset_sync", sync_error, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", outs(), pack(0, 0, 0, 1, 0, 0, 0, 0, 0));

    // Two continuous frames, enable dropped in the last plane's burst
    for (int f = 0; f < 2; f++) begin
      sbq.push_back('{row: 0, run: BT});
      sbq.push_back('{row: 0, run: BT << 1});
      sbq.push_back('{row: 1, run: BT});
      sbq.push_back('{row: 1, run: BT << 1});
    end
    mon_on = 1'b1;
    enable = 1'b1;
    for (int c = 0; c <= 90; c++) begin
      @(negedge clk);
      foreach (tbl[i]) begin
        if (tbl[i].cyc == c)
          chk($sformatf("tbl_cyc%0d", c), outs(),
              pack(tbl[i].se, tbl[i].ce, tbl[i].lat, tbl[i].oe_n,
                   tbl[i].bsy, tbl[i].fd, tbl[i].row, tbl[i].scan,
                   tbl[i].bcm));
      end
      if (c == 70) enable = 1'b0;
    end
    chk("cont_idle", outs(), pack(0, 0, 0, 1, 0, 0, 1, 0, 0));
    chk("cont_sbq_empty", sbq.size(), 0);
    chk("cont_sync_clean", sync_error, 0);

    // One-cycle enable: bit-0 plane runs to completion, bit 1 retained
    sbq.push_back('{row: 0, run: BT});
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("plane0_cycles", n, MW + 1 + BC + 1 + BT);
    chk("retained_pos", {scan_val, current_bcm_bit}, {5'd0, 2'd1});

    // Resume at bit 1, then reset in the middle of its display
    sbq.push_back('{row: 0, run: BT << 1});
    enable = 1'b1;
    @(negedge clk);
    chk("resume_first", outs(), pack(1, 0, 0, 1, 1, 0, 0, 0, 1));
    repeat (7) @(negedge clk);
    mon_on = 1'b0;
    chk("resume_sbq_empty", sbq.size(), 0);
    chk("mid_display_oe", panel_oe_n, 0);
    #1;
    rst = 1'b1;
    enable = 1'b0;
    #1;
    chk("async_rst_outs", outs(), pack(0, 0, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    chk("post_rst_first", outs(), pack(1, 0, 0, 1, 1, 0, 0, 0, 0));
    chk("post_rst_sync", sync_error, 0);

    // Early rollover flag on the second shift cycle
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("sync_set", sync_error, 1);
    repeat (20) @(negedge clk);
    chk("sync_sticky", sync_error, 1);
    enable = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
